// File: rtl/ppc440mc_arb_pkg.sv
// Shared helpers for the PPC440 MIB arbiter: ceiling log2, port-index width, address-field extraction.
package ppc440mc_arb_pkg;

  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned idx_width(input int unsigned nports);
    return (nports <= 1) ? 1 : log2c(nports);
  endfunction

  function automatic logic [31:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return 32'(addr >> lsb) & mask;
  endfunction

  function automatic logic [31:0] bank_of(input logic [63:0] addr, input int unsigned lsb,
                                          input int unsigned width);
    return addr_field(addr, lsb, width);
  endfunction

  function automatic logic [31:0] row_of(input logic [63:0] addr, input int unsigned lsb,
                                         input int unsigned width);
    return addr_field(addr, lsb, width);
  endfunction

endpackage

// File: rtl/ppc440mc_arb_tag_fifo.sv
// Synchronous tag FIFO holding the issuing port of each outstanding read; zero-latency head,
// simultaneous push/pop allowed including push while full when a pop happens in the same cycle.
module ppc440mc_arb_tag_fifo
  import ppc440mc_arb_pkg::*;
#(
  parameter int W = 2,
  parameter int D = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdat_i,
  output logic [W-1:0] rdat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = log2c(D);

  logic [W-1:0] mem_q [D];
  logic [AW:0]  wptr_q, rptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdat_i;
  end

  assign rdat_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/ppc440mc_mib_arbiter.sv
// Round-robin front end onto the MIB controller port: requests appear on mi_mc* one cycle after grant, read beats one cycle after mc_mireaddatavalid.
// Reads stall while the tag FIFO is full; PPC440MC_ARB_ROWTRACK_EN enables the open-row table for bank/row hints.
module ppc440mc_mib_arbiter
  import ppc440mc_arb_pkg::*;
#(
  parameter int C_NUM_PORTS      = 4,
  parameter int C_AWIDTH         = 36,
  parameter int C_DWIDTH         = 128,
  parameter int C_DDR_BAWIDTH    = 2,
  parameter int C_DDR_RAWIDTH    = 13,
  parameter int C_BANK_LSB       = 14,
  parameter int C_ROW_LSB        = 16,
  parameter int C_RD_BEATS       = 2,
  parameter int C_TAG_DEPTH      = 8,
  parameter int C_REFRESH_CYCLES = 780
) (
  input  logic                              mc_mibclk,
  input  logic                              mi_mcreset,
  input  logic [C_NUM_PORTS-1:0]            p_req_valid,
  output logic [C_NUM_PORTS-1:0]            p_req_ready,
  input  logic [C_NUM_PORTS-1:0]            p_req_rnw,
  input  logic [C_NUM_PORTS*C_AWIDTH-1:0]   p_req_addr,
  input  logic [C_NUM_PORTS*C_DWIDTH/8-1:0] p_req_be,
  input  logic [C_NUM_PORTS*C_DWIDTH-1:0]   p_req_wdata,
  output logic [C_DWIDTH-1:0]               p_rd_data,
  output logic [C_NUM_PORTS-1:0]            p_rd_valid,
  output logic [C_NUM_PORTS-1:0]            p_rd_err,
  output logic                              mi_mcaddressvalid,
  output logic [C_AWIDTH-1:0]               mi_mcaddress,
  output logic                              mi_mcbankconflict,
  output logic                              mi_mcrowconflict,
  output logic [C_DWIDTH/8-1:0]             mi_mcbyteenable,
  output logic [C_DWIDTH-1:0]               mi_mcwritedata,
  output logic                              mi_mcreadnotwrite,
  output logic                              mi_mcwritedatavalid,
  input  logic                              mc_miaddrreadytoaccept,
  input  logic [C_DWIDTH-1:0]               mc_mireaddata,
  input  logic                              mc_mireaddataerr,
  input  logic                              mc_mireaddatavalid,
  output logic                              rd_orphan_err
);
  localparam int IW  = idx_width(C_NUM_PORTS);
  localparam int BEW = C_DWIDTH / 8;
  localparam int BCW = log2c(C_RD_BEATS + 1);

  logic [IW-1:0]          rr_q, rr_d, win, tag_head;
  logic                   found, issue, tag_full, tag_empty, tag_push, tag_pop, last_beat;
  logic [C_NUM_PORTS-1:0] elig, head_oh;
  logic [C_AWIDTH-1:0]    sel_addr;
  logic [BEW-1:0]         sel_be;
  logic [C_DWIDTH-1:0]    sel_wd;
  logic                   sel_rnw, bank_hint, row_hint;
  logic [BCW-1:0]         bcnt_q;

  assign elig = p_req_valid & (~p_req_rnw | {C_NUM_PORTS{!tag_full}});

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < C_NUM_PORTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= C_NUM_PORTS) idx = idx - C_NUM_PORTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign issue       = found && mc_miaddrreadytoaccept;
  assign p_req_ready = issue ? ({{(C_NUM_PORTS-1){1'b0}}, 1'b1} << win) : '0;
  assign rr_d        = !issue ? rr_q : ((win == IW'(C_NUM_PORTS-1)) ? '0 : win + 1'b1);
  assign sel_addr    = p_req_addr[int'(win)*C_AWIDTH +: C_AWIDTH];
  assign sel_be      = p_req_be[int'(win)*BEW +: BEW];
  assign sel_wd      = p_req_wdata[int'(win)*C_DWIDTH +: C_DWIDTH];
  assign sel_rnw     = p_req_rnw[win];

`ifdef PPC440MC_ARB_ROWTRACK_EN
  localparam int NB  = 2 ** C_DDR_BAWIDTH;
  localparam int RCW = log2c(C_REFRESH_CYCLES);

  logic [RCW-1:0]           ref_cnt_q;
  logic [NB-1:0]            tbl_vld_q;
  logic [C_DDR_RAWIDTH-1:0] tbl_row_q [NB];
  logic [C_DDR_BAWIDTH-1:0] last_bank_q, sel_bank;
  logic [C_DDR_RAWIDTH-1:0] sel_row;
  logic                     any_iss_q, wrap;

  assign sel_bank  = C_DDR_BAWIDTH'(bank_of(64'(sel_addr), C_BANK_LSB, C_DDR_BAWIDTH));
  assign sel_row   = C_DDR_RAWIDTH'(row_of(64'(sel_addr), C_ROW_LSB, C_DDR_RAWIDTH));
  assign wrap      = (ref_cnt_q == RCW'(C_REFRESH_CYCLES - 1));
  // The wrap cycle already behaves as if the table were invalidated.
  assign bank_hint = !wrap && any_iss_q && (sel_bank == last_bank_q);
  assign row_hint  = wrap || !tbl_vld_q[sel_bank] || (tbl_row_q[sel_bank] != sel_row);

  always_ff @(posedge mc_mibclk) begin
    if (mi_mcreset) begin
      ref_cnt_q   <= '0;
      tbl_vld_q   <= '0;
      last_bank_q <= '0;
      any_iss_q   <= 1'b0;
    end else begin
      ref_cnt_q <= wrap ? '0 : ref_cnt_q + 1'b1;
      if (wrap) begin
        tbl_vld_q   <= '0;
        last_bank_q <= '0;
        any_iss_q   <= 1'b0;
      end
      if (issue) begin
        tbl_vld_q[sel_bank] <= 1'b1;
        last_bank_q         <= sel_bank;
        any_iss_q           <= 1'b1;
      end
    end
  end

  always_ff @(posedge mc_mibclk) begin
    if (issue) tbl_row_q[sel_bank] <= sel_row;
  end
`else
  assign bank_hint = 1'b1;
  assign row_hint  = 1'b1;
`endif

  assign tag_push  = issue && sel_rnw;
  assign last_beat = (bcnt_q == BCW'(C_RD_BEATS - 1));
  assign tag_pop   = mc_mireaddatavalid && !tag_empty && last_beat;
  assign head_oh   = {{(C_NUM_PORTS-1){1'b0}}, 1'b1} << tag_head;

  ppc440mc_arb_tag_fifo #(.W(IW), .D(C_TAG_DEPTH)) u_tag_fifo (
    .clk_i   (mc_mibclk),
    .rst_i   (mi_mcreset),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .wdat_i  (win),
    .rdat_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  always_ff @(posedge mc_mibclk) begin
    if (mi_mcreset) begin
      rr_q                <= '0;
      mi_mcaddressvalid   <= 1'b0;
      mi_mcwritedatavalid <= 1'b0;
      mi_mcaddress        <= '0;
      mi_mcreadnotwrite   <= 1'b0;
      mi_mcbyteenable     <= '0;
      mi_mcwritedata      <= '0;
      mi_mcbankconflict   <= 1'b0;
      mi_mcrowconflict    <= 1'b0;
      p_rd_data           <= '0;
      p_rd_valid          <= '0;
      p_rd_err            <= '0;
      bcnt_q              <= '0;
      rd_orphan_err       <= 1'b0;
    end else begin
      rr_q                <= rr_d;
      mi_mcaddressvalid   <= issue;
      mi_mcwritedatavalid <= issue && !sel_rnw;
      if (issue) begin
        mi_mcaddress      <= sel_addr;
        mi_mcreadnotwrite <= sel_rnw;
        mi_mcbyteenable   <= sel_be;
        mi_mcwritedata    <= sel_wd;
        mi_mcbankconflict <= bank_hint;
        mi_mcrowconflict  <= row_hint;
      end
      p_rd_valid <= '0;
      p_rd_err   <= '0;
      if (mc_mireaddatavalid && !tag_empty) begin
        p_rd_data  <= mc_mireaddata;
        p_rd_valid <= head_oh;
        p_rd_err   <= mc_mireaddataerr ? head_oh : '0;
        bcnt_q     <= last_beat ? '0 : bcnt_q + 1'b1;
      end
      // A beat with nothing outstanding is dropped but remembered until reset.
      if (mc_mireaddatavalid && tag_empty) rd_orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppc440mc_mib_arbiter.sv
// Randomized bench for ppc440mc_mib_arbiter: a transaction-level model predicts grants, issued requests and read beats; a monitor pops and compares.
module tb_ppc440mc_mib_arbiter;
  localparam int N = 4, AW = 36, DW = 128, BEW = 16, BA = 2, RA = 13;
  localparam int BLSB = 14, RLSB = 16, BEATS = 2, TAGD = 8, REFC = 780;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              mi_mcreset;
  logic [N-1:0]      p_req_valid, p_req_ready, p_req_rnw, p_rd_valid, p_rd_err;
  logic [N*AW-1:0]   p_req_addr;
  logic [N*BEW-1:0]  p_req_be;
  logic [N*DW-1:0]   p_req_wdata;
  logic [DW-1:0]     p_rd_data, mi_mcwritedata, mc_mireaddata;
  logic [AW-1:0]     mi_mcaddress;
  logic [BEW-1:0]    mi_mcbyteenable;
  logic              mi_mcaddressvalid, mi_mcbankconflict, mi_mcrowconflict;
  logic              mi_mcreadnotwrite, mi_mcwritedatavalid, mc_miaddrreadytoaccept;
  logic              mc_mireaddataerr, mc_mireaddatavalid, rd_orphan_err;

  ppc440mc_mib_arbiter dut (
    .mc_mibclk(clk), .mi_mcreset(mi_mcreset),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_rnw(p_req_rnw),
    .p_req_addr(p_req_addr), .p_req_be(p_req_be), .p_req_wdata(p_req_wdata),
    .p_rd_data(p_rd_data), .p_rd_valid(p_rd_valid), .p_rd_err(p_rd_err),
    .mi_mcaddressvalid(mi_mcaddressvalid), .mi_mcaddress(mi_mcaddress),
    .mi_mcbankconflict(mi_mcbankconflict), .mi_mcrowconflict(mi_mcrowconflict),
    .mi_mcbyteenable(mi_mcbyteenable), .mi_mcwritedata(mi_mcwritedata),
    .mi_mcreadnotwrite(mi_mcreadnotwrite), .mi_mcwritedatavalid(mi_mcwritedatavalid),
    .mc_miaddrreadytoaccept(mc_miaddrreadytoaccept), .mc_mireaddata(mc_mireaddata),
    .mc_mireaddataerr(mc_mireaddataerr), .mc_mireaddatavalid(mc_mireaddatavalid),
    .rd_orphan_err(rd_orphan_err)
  );

  typedef struct {
    logic [AW-1:0]  addr;
    logic           rnw;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wd;
    logic           bc;
    logic           rc;
  } txn_t;
  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] dat;
    logic [N-1:0]  err;
  } beat_t;

  txn_t  exp_txn[$];
  beat_t exp_beat[$];
  txn_t  mt;
  beat_t mb;
  int    checks = 0, passes = 0;
  bit    mon_en = 1'b0;

  // Reference model state: pending client requests, outstanding read tags, open rows.
  bit [N-1:0]     pend;
  logic           p_rnw  [N];
  logic [AW-1:0]  p_addr [N];
  logic [BEW-1:0] p_be   [N];
  logic [DW-1:0]  p_wd   [N];
  int             tags[$];
  int             beat_n, last_win, cyc;
  bit             orph;
`ifdef PPC440MC_ARB_ROWTRACK_EN
  bit [3:0]       tbl_v;
  int             tbl_r [4];
  int             last_bank;
  bit             any_iss;
`endif

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] mk_addr();
    logic [AW-1:0] a;
    a = AW'({$urandom, $urandom});
    a[BLSB +: BA] = BA'($urandom_range(3));
    a[RLSB +: RA] = RA'($urandom_range(2));
    return a;
  endfunction

  task automatic do_reset(input bit chk);
    @(negedge clk);
    mi_mcreset = 1'b1;
    p_req_valid = '0;
    mc_miaddrreadytoaccept = 1'b0;
    mc_mireaddatavalid = 1'b0;
    #1;
    pend = '0; tags.delete(); beat_n = 0; orph = 1'b0; last_win = N - 1; cyc = 0;
`ifdef PPC440MC_ARB_ROWTRACK_EN
    tbl_v = '0; any_iss = 1'b0; last_bank = 0;
`endif
    @(negedge clk);
    if (chk) begin
      check("rst_addressvalid", DW'(mi_mcaddressvalid), '0);
      check("rst_wdatavalid", DW'(mi_mcwritedatavalid), '0);
      check("rst_address", DW'(mi_mcaddress), '0);
      check("rst_hints", DW'({mi_mcbankconflict, mi_mcrowconflict, mi_mcreadnotwrite}), '0);
      check("rst_be_wdata", DW'(mi_mcbyteenable) | mi_mcwritedata, '0);
      check("rst_rd_valid_err", DW'({p_rd_valid, p_rd_err}), '0);
      check("rst_rd_data", p_rd_data, '0);
      check("rst_orphan", DW'(rd_orphan_err), '0);
    end
  endtask

  task automatic step(input int new_pct, input int rd_pct, input int beat_pct, input int orph_pct);
    int win, pi;
    bit full, issue, push;
    logic [N-1:0] exp_rdy;
    txn_t t;
    beat_t b;
`ifdef PPC440MC_ARB_ROWTRACK_EN
    int bank, row;
`endif
    @(negedge clk);
    mi_mcreset = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!pend[p] && $urandom_range(99) < new_pct) begin
        pend[p]   = 1'b1;
        p_rnw[p]  = ($urandom_range(99) < rd_pct);
        p_addr[p] = mk_addr();
        p_be[p]   = BEW'($urandom);
        p_wd[p]   = {$urandom, $urandom, $urandom, $urandom};
      end
      p_req_valid[p] = pend[p];
      p_req_rnw[p]   = p_rnw[p];
      p_req_addr[p*AW +: AW]    = p_addr[p];
      p_req_be[p*BEW +: BEW]    = p_be[p];
      p_req_wdata[p*DW +: DW]   = p_wd[p];
    end
    mc_miaddrreadytoaccept = ($urandom_range(99) < 75);
    if (tags.size() > 0) mc_mireaddatavalid = ($urandom_range(99) < beat_pct);
    else mc_mireaddatavalid = ($urandom_range(99) < orph_pct);
    mc_mireaddata    = {$urandom, $urandom, $urandom, $urandom};
    mc_mireaddataerr = ($urandom_range(7) == 0);
    #1;
    full = (tags.size() >= TAGD);
    win = -1;
    for (int k = 1; k <= N; k++) begin
      pi = (last_win + k) % N;
      if (win < 0 && pend[pi] && (!p_rnw[pi] || !full)) win = pi;
    end
    issue = (win >= 0) && mc_miaddrreadytoaccept;
    exp_rdy = issue ? (N'(1) << win) : '0;
    check("p_req_ready", DW'(p_req_ready), DW'(exp_rdy));
`ifdef PPC440MC_ARB_ROWTRACK_EN
    if (cyc % REFC == REFC - 1) begin
      tbl_v = '0;
      any_iss = 1'b0;
    end
`endif
    push = 1'b0;
    if (issue) begin
      t.addr = p_addr[win]; t.rnw = p_rnw[win]; t.be = p_be[win]; t.wd = p_wd[win];
`ifdef PPC440MC_ARB_ROWTRACK_EN
      bank = int'((p_addr[win] >> BLSB) % (1 << BA));
      row  = int'((p_addr[win] >> RLSB) % (1 << RA));
      t.bc = any_iss && (bank == last_bank);
      t.rc = !tbl_v[bank] || (tbl_r[bank] != row);
      tbl_v[bank] = 1'b1; tbl_r[bank] = row; last_bank = bank; any_iss = 1'b1;
`else
      t.bc = 1'b1;
      t.rc = 1'b1;
`endif
      exp_txn.push_back(t);
      push = p_rnw[win];
      last_win = win;
      pend[win] = 1'b0;
    end
    if (mc_mireaddatavalid) begin
      if (tags.size() == 0) orph = 1'b1;
      else begin
        b.vld = N'(1) << tags[0];
        b.dat = mc_mireaddata;
        b.err = mc_mireaddataerr ? b.vld : '0;
        exp_beat.push_back(b);
        beat_n++;
        if (beat_n == BEATS) begin
          beat_n = 0;
          void'(tags.pop_front());
        end
      end
    end
    if (push) tags.push_back(win);
    cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mi_mcaddressvalid) begin
          if (exp_txn.size() == 0) check("spurious_issue", DW'(1), '0);
          else begin
            mt = exp_txn.pop_front();
            check("mi_mcaddress", DW'(mi_mcaddress), DW'(mt.addr));
            check("mi_mcreadnotwrite", DW'(mi_mcreadnotwrite), DW'(mt.rnw));
            check("mi_mcwritedatavalid", DW'(mi_mcwritedatavalid), DW'(!mt.rnw));
            check("mi_mcbyteenable", DW'(mi_mcbyteenable), DW'(mt.be));
            check("mi_mcwritedata", mi_mcwritedata, mt.wd);
            check("mi_mcbankconflict", DW'(mi_mcbankconflict), DW'(mt.bc));
            check("mi_mcrowconflict", DW'(mi_mcrowconflict), DW'(mt.rc));
          end
        end else begin
          check("wdatavalid_idle", DW'(mi_mcwritedatavalid), '0);
        end
        if (|p_rd_valid) begin
          if (exp_beat.size() == 0) check("spurious_rd_beat", DW'(p_rd_valid), '0);
          else begin
            mb = exp_beat.pop_front();
            check("p_rd_valid", DW'(p_rd_valid), DW'(mb.vld));
            check("p_rd_data", p_rd_data, mb.dat);
            check("p_rd_err", DW'(p_rd_err), DW'(mb.err));
          end
        end
        check("rd_orphan_err", DW'(rd_orphan_err), DW'(orph));
      end
    end
  end

  initial begin
    mi_mcreset = 1'b1;
    p_req_valid = '0; p_req_rnw = '0; p_req_addr = '0; p_req_be = '0; p_req_wdata = '0;
    mc_miaddrreadytoaccept = 1'b0; mc_mireaddata = '0;
    mc_mireaddataerr = 1'b0; mc_mireaddatavalid = 1'b0;
    do_reset(1'b1);
    mon_en = 1'b1;
    // Slow read return first so the tag FIFO fills and reads stall behind writes.
    repeat (1200) step(50, 60, 8, 0);
    repeat (1800) step(50, 50, 50, 0);
    // Reset with reads in flight, then return beats nobody is waiting for.
    do_reset(1'b0);
    step(50, 50, 30, 100);
    repeat (300) step(50, 50, 30, 5);
    repeat (100) step(0, 0, 60, 0);
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    check("txn_queue_drained", DW'(exp_txn.size()), '0);
    check("beat_queue_drained", DW'(exp_beat.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
